// File: rtl/bp_me_clint_mc_pkg.sv
// Shared definitions for the multi-hart CLINT: register base offsets, the
// command record and the byte-masked merge used by every 64-bit register.
package bp_me_clint_mc_pkg;

    localparam int clint_offset_width_gp = 16;
    localparam int clint_dword_width_gp  = 64;

    typedef enum logic [15:0] {
        e_clint_msip_off     = 16'h0000,
        e_clint_mtimecmp_off = 16'h4000,
        e_clint_prescale_off = 16'hBFF0,
        e_clint_mtime_off    = 16'hBFF8
    } bp_clint_mc_offset_e;

    typedef struct packed {
        logic                             w;
        logic [clint_offset_width_gp-1:0] addr;
        logic [7:0]                       mask;
        logic [clint_dword_width_gp-1:0]  data;
    } bp_clint_mc_cmd_s;

    localparam logic [0:0] e_clint_ready = 1'b0;
    localparam logic [0:0] e_clint_resp  = 1'b1;

    function automatic logic [63:0] bp_clint_mask_merge(
        input logic [63:0] old_i,
        input logic [63:0] new_i,
        input logic [7:0]  mask_i
    );
        logic [63:0] merged;
        merged = old_i;
        for (int b = 0; b < 8; b++) begin
            if (mask_i[b]) merged[8*b +: 8] = new_i[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/bp_me_clint_timebase.sv
// RTC prescaler and shared 64-bit mtime; a software write to mtime overrides
// any increment landing in the same cycle.
module bp_me_clint_timebase
    import bp_me_clint_mc_pkg::*;
#(
    parameter int prescale_width_p = 8
)
(
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        tick_i,
    input  logic [prescale_width_p-1:0] prescale_i,
    input  logic                        prescale_w_i,
    input  logic                        mtime_w_i,
    input  logic [63:0]                 mtime_data_i,
    input  logic [7:0]                  mtime_mask_i,
    output logic [63:0]                 mtime_o
);

    logic [prescale_width_p-1:0] count_q, count_d;
    logic [63:0]                 mtime_q, mtime_d;
    logic                        roll;

    assign roll = tick_i & (count_q == prescale_i);

    always_comb begin
        count_d = count_q;
        if (tick_i) count_d = roll ? '0 : count_q + 1'b1;
        if (prescale_w_i) count_d = '0;
    end

    always_comb begin
        mtime_d = mtime_q;
        if (roll) mtime_d = mtime_q + 64'd1;
        if (mtime_w_i) mtime_d = bp_clint_mask_merge(mtime_q, mtime_data_i, mtime_mask_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            mtime_q <= '0;
        end else begin
            count_q <= count_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/bp_me_clint_mc.sv
// Multi-hart CLINT: msip/mtimecmp per hart, shared prescaled mtime, one
// outstanding request on a valid/ready command/response port.
//   state | meaning
//   READY | accepting a command
//   RESP  | holding registered response until resp_ready_and_i
module bp_me_clint_mc
    import bp_me_clint_mc_pkg::*;
#(
    parameter int num_core_p       = 4,
    parameter int dword_width_p    = 64,
    parameter int prescale_width_p = 8,
    parameter int offset_width_p   = 16
)
(
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      rtc_tick_i,
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_and_o,
    input  logic                      cmd_w_i,
    input  logic [offset_width_p-1:0] cmd_addr_i,
    input  logic [7:0]                cmd_mask_i,
    input  logic [dword_width_p-1:0]  cmd_data_i,
    output logic                      resp_v_o,
    input  logic                      resp_ready_and_i,
    output logic [dword_width_p-1:0]  resp_data_o,
    output logic                      resp_err_o,
    output logic [num_core_p-1:0]     software_irq_o,
    output logic [num_core_p-1:0]     timer_irq_o
);

    logic [0:0]                  state_q, state_d;
    logic [dword_width_p-1:0]    resp_data_q, resp_data_d;
    logic                        resp_err_q, resp_err_d;
    logic [dword_width_p-1:0]    mtimecmp_q [num_core_p];
    logic [dword_width_p-1:0]    mtimecmp_d [num_core_p];
    logic [num_core_p-1:0]       msip_q, msip_d;
    logic [prescale_width_p-1:0] prescale_q, prescale_d;
    logic [dword_width_p-1:0]    mtime;
    logic [dword_width_p-1:0]    rdata;
    logic [num_core_p-1:0]       msip_hit, cmp_hit;
    logic                        prescale_hit, mtime_hit, addr_err, accept, wr_ok;

    assign cmd_ready_and_o = (state_q == e_clint_ready);
    assign resp_v_o        = (state_q == e_clint_resp);
    assign resp_data_o     = resp_data_q;
    assign resp_err_o      = resp_err_q;
    assign accept          = cmd_v_i & cmd_ready_and_o;

    // Exact-match decode per register rules out misalignment and absent harts at once.
    always_comb begin
        for (int h = 0; h < num_core_p; h++) begin
            msip_hit[h] = (cmd_addr_i == offset_width_p'(int'(e_clint_msip_off) + 4*h));
            cmp_hit[h]  = (cmd_addr_i == offset_width_p'(int'(e_clint_mtimecmp_off) + 8*h));
        end
    end

    assign prescale_hit = (cmd_addr_i == offset_width_p'(e_clint_prescale_off));
    assign mtime_hit    = (cmd_addr_i == offset_width_p'(e_clint_mtime_off));
    assign addr_err     = ~((|msip_hit) | (|cmp_hit) | prescale_hit | mtime_hit);
    assign wr_ok        = accept & cmd_w_i & ~addr_err;

    always_comb begin
        rdata = '0;
        for (int h = 0; h < num_core_p; h++) begin
            if (msip_hit[h]) rdata = {{(dword_width_p-1){1'b0}}, msip_q[h]};
            if (cmp_hit[h])  rdata = mtimecmp_q[h];
        end
        if (prescale_hit) rdata = dword_width_p'(prescale_q);
        if (mtime_hit)    rdata = mtime;
    end

    always_comb begin
        msip_d     = msip_q;
        prescale_d = prescale_q;
        for (int h = 0; h < num_core_p; h++) begin
            mtimecmp_d[h] = mtimecmp_q[h];
            if (wr_ok & cmp_hit[h])
                mtimecmp_d[h] = bp_clint_mask_merge(mtimecmp_q[h], cmd_data_i, cmd_mask_i);
            if (wr_ok & msip_hit[h] & cmd_mask_i[0])
                msip_d[h] = cmd_data_i[0];
        end
        if (wr_ok & prescale_hit)
            prescale_d = prescale_width_p'(
                bp_clint_mask_merge(dword_width_p'(prescale_q), cmd_data_i, cmd_mask_i));
    end

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            e_clint_ready: if (accept) begin
                state_d     = e_clint_resp;
                resp_data_d = (cmd_w_i | addr_err) ? '0 : rdata;
                resp_err_d  = addr_err;
            end
            default: if (resp_ready_and_i) state_d = e_clint_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_clint_ready;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            msip_q      <= '0;
            prescale_q  <= '0;
            for (int h = 0; h < num_core_p; h++) mtimecmp_q[h] <= '1;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            msip_q      <= msip_d;
            prescale_q  <= prescale_d;
            for (int h = 0; h < num_core_p; h++) mtimecmp_q[h] <= mtimecmp_d[h];
        end
    end

    bp_me_clint_timebase #(
        .prescale_width_p(prescale_width_p)
    ) timebase (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .tick_i       (rtc_tick_i),
        .prescale_i   (prescale_q),
        .prescale_w_i (wr_ok & prescale_hit),
        .mtime_w_i    (wr_ok & mtime_hit),
        .mtime_data_i (cmd_data_i),
        .mtime_mask_i (cmd_mask_i),
        .mtime_o      (mtime)
    );

    assign software_irq_o = msip_q;

    for (genvar h = 0; h < num_core_p; h++) begin : g_cmp
        assign timer_irq_o[h] = (mtime >= mtimecmp_q[h]);
    end

endmodule
